// File: rtl/caliptra_imem_arb.sv
// rtl/caliptra_imem_arb.sv - imem single-port arbiter between core reads and a buffered loader write path
// Loader writes queue in an in-order FIFO; core reads win unless they hit a buffered address or starve the loader.
module caliptra_imem_arb #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 64,
    parameter int WBUF_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int PTR_W    = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W    = $clog2(WBUF_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0]     addr_mem [WBUF_DEPTH];
    logic [DATA_W-1:0]     data_mem [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  rvalid_q;

    logic buf_empty;
    logic hazard;
    logic wr_gnt;
    logic core_win;
    logic push;
    logic pop;

    assign buf_empty = (count_q == '0);
    assign ld_ready  = rst || (count_q < CNT_W'(WBUF_DEPTH));
    assign ld_busy   = !buf_empty;
    assign push      = ld_valid && ld_ready && !rst;
    assign pop       = wr_gnt;

    // Entries pushed this cycle are not yet valid, so they cannot be written or stall a read until next cycle.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (valid_q[i] && (addr_mem[i] == core_addr)) begin
                hazard = core_req;
            end
        end
    end

    always_comb begin
        core_gnt = 1'b0;
        wr_gnt   = 1'b0;
        core_win = 1'b0;
        if (!rst) begin
            if (buf_empty) begin
                core_gnt = core_req;
            end else if (!core_req) begin
                wr_gnt = 1'b1;
            end else if (hazard || (starve_q == STARVE_W'(STARVE_MAX))) begin
                wr_gnt = 1'b1;
            end else begin
                core_gnt = 1'b1;
                core_win = 1'b1;
            end
        end
    end

    always_comb begin
        sram_cs    = core_gnt || wr_gnt;
        sram_we    = wr_gnt;
        sram_addr  = wr_gnt ? addr_mem[rd_ptr_q] : core_addr;
        sram_wdata = data_mem[rd_ptr_q];
    end

    assign core_rvalid = rvalid_q;
    assign core_rdata  = rvalid_q ? sram_rdata : '0;

    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (wr_gnt || buf_empty) begin
            starve_d = '0;
        end else if (core_win && (starve_q < STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            rvalid_q <= core_gnt;
        end
    end

    // Payload storage carries no reset; valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= ld_addr;
            data_mem[wr_ptr_q] <= ld_wdata;
        end
    end

endmodule

// File: tb/tb_caliptra_imem_arb.sv
// tb/tb_caliptra_imem_arb.sv - directed self-checking bench for caliptra_imem_arb
module tb_caliptra_imem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [12:0] core_addr;
    logic        core_gnt;
    logic        core_rvalid;
    logic [63:0] core_rdata;
    logic        ld_valid;
    logic [12:0] ld_addr;
    logic [63:0] ld_wdata;
    logic        ld_ready;
    logic        ld_busy;
    logic        sram_cs;
    logic        sram_we;
    logic [12:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata;

    int checks   = 0;
    int failures = 0;

    bit [63:0]   mem   [8192];
    bit          wflag [8192];
    logic [12:0] waddr_log [$];
    logic [63:0] wdata_log [$];

    always #5 clk = ~clk;

    caliptra_imem_arb #(
        .ADDR_W(13), .DATA_W(64), .WBUF_DEPTH(4), .STARVE_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ready(ld_ready), .ld_busy(ld_busy),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Unwritten words read back as 0xC0DE000000000000 | addr.
    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            mem[sram_addr]   <= sram_wdata;
            wflag[sram_addr] <= 1'b1;
            waddr_log.push_back(sram_addr);
            wdata_log.push_back(sram_wdata);
        end
        if (sram_cs && !sram_we) begin
            sram_rdata <= wflag[sram_addr] ? mem[sram_addr] : (64'hC0DE_0000_0000_0000 | 64'(sram_addr));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic cr, input logic [12:0] ca,
                         input logic lv, input logic [12:0] la, input logic [63:0] ld);
        rst = r; core_req = cr; core_addr = ca;
        ld_valid = lv; ld_addr = la; ld_wdata = ld;
        #1;
    endtask

    initial begin
        sram_rdata = '0;
        drive(1, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        drive(1, 1, 13'h10, 1, 13'h11, 64'h99);
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_sram_cs", sram_cs, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_rvalid", core_rvalid, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("post_rst_busy", ld_busy, 0);
        chk("post_rst_cs", sram_cs, 0);

        // Core streaming reads with an empty buffer
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(0, 1, 13'h10, 0, 0, 0);
            chk("rd_gnt", core_gnt, 1);
            chk("rd_cs", sram_cs, 1);
            chk("rd_we", sram_we, 0);
            chk("rd_addr", sram_addr, 13'h10);
            if (i > 0) begin
                chk("rd_rvalid", core_rvalid, 1);
                chk("rd_rdata", core_rdata, 64'hC0DE_0000_0000_0010);
            end
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("rd_tail_rvalid", core_rvalid, 1);
        chk("rd_tail_rdata", core_rdata, 64'hC0DE_0000_0000_0010);
        next_cycle();
        chk("rd_idle_rvalid", core_rvalid, 0);
        chk("rd_idle_rdata", core_rdata, 0);

        // Five back-to-back loader writes, core idle
        waddr_log.delete(); wdata_log.delete();
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            drive(0, 0, 0, 1, 13'(13'h50 + k), 64'(64'hD0 + k));
            chk("ld5_ready", ld_ready, 1);
            if (k == 0) chk("ld5_nobypass", sram_cs, 0);
            else begin
                chk("ld5_we", sram_we, 1);
                chk("ld5_addr", sram_addr, 13'(13'h50 + k - 1));
            end
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("ld5_last_we", sram_we, 1);
        chk("ld5_last_addr", sram_addr, 13'h54);
        chk("ld5_last_busy", ld_busy, 1);
        next_cycle();
        chk("ld5_busy_fall", ld_busy, 0);
        chk("ld5_idle_cs", sram_cs, 0);
        chk("ld5_log_size", 64'(waddr_log.size()), 5);
        for (int k = 0; k < 5 && k < waddr_log.size(); k++) begin
            chk("ld5_log_addr", waddr_log[k], 13'(13'h50 + k));
            chk("ld5_log_data", wdata_log[k], 64'(64'hD0 + k));
        end

        // Fill the buffer while the core holds the port
        waddr_log.delete(); wdata_log.delete();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive(0, 1, 13'h100, 1, 13'(13'h60 + k), 64'(64'hE0 + k));
            chk("fill_ready", ld_ready, 1);
            chk("fill_core_gnt", core_gnt, 1);
        end
        next_cycle();
        drive(0, 1, 13'h100, 1, 13'h64, 64'hE4);
        chk("full_ready", ld_ready, 0);
        chk("full_busy", ld_busy, 1);
        chk("full_core_gnt", core_gnt, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("full_drain_ready", ld_ready, 0);
        chk("full_drain_we", sram_we, 1);
        chk("full_drain_addr", sram_addr, 13'h60);
        for (int k = 1; k < 4; k++) begin
            next_cycle();
            chk("fill_drain_ready", ld_ready, 1);
            chk("fill_drain_addr", sram_addr, 13'(13'h60 + k));
            chk("fill_drain_wdata", sram_wdata, 64'(64'hE0 + k));
        end
        next_cycle();
        chk("fill_busy_fall", ld_busy, 0);
        chk("fill_log_size", 64'(waddr_log.size()), 4);

        // Starvation bound: 8 core grants then one forced write
        waddr_log.delete(); wdata_log.delete();
        next_cycle();
        drive(0, 0, 0, 1, 13'h20, 64'hBEEF);
        chk("stv_push_gnt", core_gnt, 0);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            drive(0, 1, 13'h30, 0, 0, 0);
            chk("stv_core_gnt", core_gnt, 1);
            chk("stv_we", sram_we, 0);
        end
        next_cycle();
        chk("stv_forced_gnt", core_gnt, 0);
        chk("stv_forced_we", sram_we, 1);
        chk("stv_forced_addr", sram_addr, 13'h20);
        chk("stv_forced_wdata", sram_wdata, 64'hBEEF);
        next_cycle();
        chk("stv_resume_gnt", core_gnt, 1);
        chk("stv_resume_busy", ld_busy, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Read-after-write hazard with two matching entries
        next_cycle();
        drive(0, 0, 0, 1, 13'h40, 64'h1111);
        next_cycle();
        drive(0, 1, 13'h40, 1, 13'h40, 64'hA5A5);
        chk("haz1_gnt", core_gnt, 0);
        chk("haz1_we", sram_we, 1);
        chk("haz1_wdata", sram_wdata, 64'h1111);
        next_cycle();
        drive(0, 1, 13'h40, 0, 0, 0);
        chk("haz2_gnt", core_gnt, 0);
        chk("haz2_we", sram_we, 1);
        chk("haz2_wdata", sram_wdata, 64'hA5A5);
        next_cycle();
        chk("haz_rd_gnt", core_gnt, 1);
        chk("haz_rd_addr", sram_addr, 13'h40);
        chk("haz_rd_we", sram_we, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("haz_rvalid", core_rvalid, 1);
        chk("haz_rdata", core_rdata, 64'hA5A5);

        // Reset while three entries are buffered
        waddr_log.delete(); wdata_log.delete();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(0, 1, 13'h200, 1, 13'(13'h80 + k), 64'(64'hF0 + k));
        end
        next_cycle();
        drive(1, 1, 13'h200, 0, 0, 0);
        chk("mrst_gnt", core_gnt, 0);
        chk("mrst_cs", sram_cs, 0);
        chk("mrst_ready", ld_ready, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("mrst_busy", ld_busy, 0);
        chk("mrst_ready_after", ld_ready, 1);
        chk("mrst_cs_after", sram_cs, 0);
        next_cycle();
        drive(0, 0, 0, 1, 13'h70, 64'h77);
        chk("mrst_push_cs", sram_cs, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("mrst_first_we", sram_we, 1);
        chk("mrst_first_addr", sram_addr, 13'h70);
        chk("mrst_first_wdata", sram_wdata, 64'h77);
        next_cycle();
        chk("mrst_done_busy", ld_busy, 0);
        chk("mrst_log_size", 64'(waddr_log.size()), 1);
        if (waddr_log.size() > 0) chk("mrst_log_addr", waddr_log[0], 13'h70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
